// File: rtl/minmax_filter_pkg.sv
// minmax_filter shared types: FSM state and width helpers.
// Imported by the filter top and its window buffer.
package minmax_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int range_w(input int dw);
    return dw + 1;
  endfunction

  localparam int DEF_LOOK_BACK = 500;
  localparam int DEF_PTR_W = ptr_w(DEF_LOOK_BACK);

endpackage

// File: rtl/minmax_window_buf.sv
// Circular sample RAM: synchronous write, registered 1-cycle read.
// Contents are never reset; validity is tracked by the filter.
module minmax_window_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 500,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/minmax_filter.sv
// Sliding-window max-min range detector with hysteresis trigger.
// Define MINMAX_FILTER_STATS_EN to expose range/min/max outputs.
module minmax_filter
  import minmax_filter_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int LOOK_BACK         = 500,
  parameter int LOW_THRESHOLD     = 37,
  parameter int HIGH_THRESHOLD    = 74
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
`ifdef MINMAX_FILTER_STATS_EN
  output logic [SAMPLE_DATA_WIDTH:0]   range_out,
  output logic [SAMPLE_DATA_WIDTH-1:0] win_min,
  output logic [SAMPLE_DATA_WIDTH-1:0] win_max,
  output logic                         range_valid,
`endif
  output logic                         triggered
);

  localparam int W  = SAMPLE_DATA_WIDTH;
  localparam int AW = ptr_w(LOOK_BACK);
  localparam int CW = cnt_w(LOOK_BACK);
  localparam int RW = range_w(W);

  localparam logic [CW-1:0] FULL = CW'(LOOK_BACK);
  localparam logic [AW-1:0] LAST = AW'(LOOK_BACK - 1);
  localparam logic [RW-1:0] HI   = RW'(HIGH_THRESHOLD);
  localparam logic [RW-1:0] LO   = RW'(LOW_THRESHOLD);

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  state_t state, state_nx;

  logic [AW-1:0]        wptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        scan_idx;
  logic                 rd_vld;
  logic signed [W-1:0]  rdata;
  logic signed [W-1:0]  cur_min;
  logic signed [W-1:0]  cur_max;
  logic [RW-1:0]        rng;
  logic                 rd_en;
  logic                 scan_done;
  logic                 upd;

  minmax_window_buf #(
    .DW    (W),
    .DEPTH (LOOK_BACK),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (axiiv),
    .waddr (wptr),
    .wdata (axiid),
    .re    (rd_en),
    .raddr (AW'(scan_idx)),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (axiiv) state_nx = SCAN;
      SCAN: begin
        if (axiiv)          state_nx = SCAN;
        else if (scan_done) state_nx = UPDATE;
      end
      UPDATE:  state_nx = axiiv ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A new sample always preempts the scan, so reads stop while axiiv is high.
  always_comb begin
    rd_en     = 1'b0;
    scan_done = 1'b0;
    upd       = 1'b0;
    unique case (1'b1)
      state == SCAN: begin
        rd_en     = !axiiv && (scan_idx != count);
        scan_done = rd_vld && (scan_idx == count);
      end
      state == UPDATE: upd = !axiiv;
      default: ;
    endcase
  end

  assign rng = {cur_max[W-1], cur_max} - {cur_min[W-1], cur_min};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      count     <= '0;
      scan_idx  <= '0;
      rd_vld    <= 1'b0;
      cur_min   <= SMAX;
      cur_max   <= SMIN;
      triggered <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (axiiv) begin
        wptr     <= (wptr == LAST) ? '0 : wptr + 1'b1;
        count    <= (count == FULL) ? count : count + 1'b1;
        scan_idx <= '0;
        cur_min  <= SMAX;
        cur_max  <= SMIN;
      end else begin
        if (rd_en) scan_idx <= scan_idx + 1'b1;
        if (rd_vld && state == SCAN) begin
          if (rdata < cur_min) cur_min <= rdata;
          if (rdata > cur_max) cur_max <= rdata;
        end
      end
      if (upd) begin
        if (rng > HI)      triggered <= 1'b1;
        else if (rng < LO) triggered <= 1'b0;
      end
    end
  end

`ifdef MINMAX_FILTER_STATS_EN
  assign range_valid = upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      range_out <= '0;
      win_min   <= '0;
      win_max   <= '0;
    end else if (upd) begin
      range_out <= rng;
      win_min   <= cur_min;
      win_max   <= cur_max;
    end
  end
`endif

endmodule

// File: tb/tb_minmax_filter.sv
// Directed bench for minmax_filter (default parameters).
// Inputs change and outputs are sampled on the falling edge.
module tb_minmax_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [7:0] axiid = 8'h00;
  logic       triggered;
`ifdef MINMAX_FILTER_STATS_EN
  logic [8:0] range_out;
  logic [7:0] win_min;
  logic [7:0] win_max;
  logic       range_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_filter dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
`ifdef MINMAX_FILTER_STATS_EN
    .range_out   (range_out),
    .win_min     (win_min),
    .win_max     (win_max),
    .range_valid (range_valid),
`endif
    .triggered   (triggered)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    axiid = v;
    axiiv = 1'b1;
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    repeat (499) send(a);
    send(b);
  endtask

  initial begin
    idle(3);
    chk("reset_trig", triggered, 0);
    rst = 1'b1;
    idle(1);

    repeat (600) send(8'd5);
    idle(505);
    chk("const5", triggered, 0);
`ifdef MINMAX_FILTER_STATS_EN
    chk("const5_range", range_out, 0);
`endif

    do_reset();
    send(8'd0);
    send(8'd80);
    idle(3);
    chk("lat2_early", triggered, 0);
    idle(1);
    chk("lat2", triggered, 1);

    do_reset();
    for (int i = 0; i < 250; i++) begin
      send(8'hD8);
      send(8'h28);
    end
    idle(505);
    chk("pm40_full", triggered, 1);
    repeat (499) send(8'd0);
    idle(505);
    chk("pm40_last", triggered, 1);
    send(8'd0);
    idle(505);
    chk("pm40_gone", triggered, 0);

    fill(8'd0, 8'd74);
    idle(505);
    chk("rng74", triggered, 0);
    fill(8'd0, 8'd75);
    idle(501);
    chk("rng75_early", triggered, 0);
    idle(1);
    chk("rng75", triggered, 1);
    fill(8'd0, 8'd50);
    idle(505);
    chk("rng50", triggered, 1);
    fill(8'd0, 8'd37);
    idle(505);
    chk("rng37", triggered, 1);
    fill(8'd0, 8'd36);
    idle(505);
    chk("rng36", triggered, 0);

    send(8'd100);
    idle(9);
    send(8'd0);
    idle(501);
    chk("restart_early", triggered, 0);
    idle(1);
    chk("restart", triggered, 1);

    send(8'd0);
    idle(10);
    rst = 1'b0;
    #1;
    chk("rst_mid", triggered, 0);
    @(negedge clk);
    send(8'h7F);
    rst = 1'b1;
    idle(1);
    send(8'h80);
    idle(5);
    chk("rst_axiiv", triggered, 0);
    send(8'h7F);
    idle(3);
    chk("ext_early", triggered, 0);
    idle(1);
    chk("ext_255", triggered, 1);
`ifdef MINMAX_FILTER_STATS_EN
    chk("ext_range", range_out, 255);
    chk("ext_min", win_min, 8'h80);
    chk("ext_max", win_max, 8'h7F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minmax_filter.md
Name: minmax_filter

Overview:
Streaming envelope/trigger detector for signed sample streams, e.g. keyed radio baseband at roughly 10 kSps on a 100 MHz clock.
- Maintains a sliding window of the last LOOK_BACK accepted samples and computes range = max − min over that window.
- Drives a hysteresis trigger from that range.
- Sits after the sample decimator; triggered feeds downstream capture/control logic.

Parameters:
- SAMPLE_DATA_WIDTH, 8: width of signed two's-complement input samples.
- LOOK_BACK, 500: window length in samples; must be ≥ 2.
- LOW_THRESHOLD, 37: triggered deasserts when range < this value; unsigned.
- HIGH_THRESHOLD, 74: triggered asserts when range > this value; unsigned; must be ≥ LOW_THRESHOLD.

Ports:
- clk, input, 1: single clock domain, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- axiiv, input, 1: sample valid. One-cycle pulse per sample; no backpressure.
- axiid, input, SAMPLE_DATA_WIDTH: signed sample; sampled when axiiv=1.
- triggered, output, 1: hysteresis trigger output, registered.

Behaviour:
- Reset (rst=0, asynchronous): triggered=0, fill count=0, write pointer=0, internal range=0, FSM=IDLE. Buffer contents need not be cleared.
- Storage: circular buffer of LOOK_BACK × SAMPLE_DATA_WIDTH.
  - On axiiv=1, axiid is written at the write pointer.
  - The pointer wraps LOOK_BACK−1 → 0.
  - Fill count saturates at LOOK_BACK.
- Window: only the last min(count, LOOK_BACK) samples are considered. A single sample gives range 0.
- FSM states:
  - IDLE: wait for axiiv; write the sample; go to SCAN.
  - SCAN: read one buffer entry per cycle over the valid entries, tracking signed min/max.
  - UPDATE: compute range; apply hysteresis; go to IDLE.
- Range arithmetic: range = max − min, computed in SAMPLE_DATA_WIDTH+1 bits and treated as unsigned. No overflow is possible (e.g. 127 − (−128) = 255).
- Hysteresis:
  - If range > HIGH_THRESHOLD, triggered←1.
  - Else if range < LOW_THRESHOLD, triggered←0.
  - Otherwise triggered holds its value.
  - Comparisons are strict: range==74 does not assert; range==37 does not deassert.
- Latency: triggered updates exactly count_valid+2 cycles after the axiiv cycle, i.e. LOOK_BACK+2 cycles with a full window. It holds between updates.
- Sample arriving during SCAN/UPDATE: it is written and counted normally, and the scan restarts from the beginning including that sample. No sample is ever dropped. An aborted scan produces no triggered update.
- Simultaneous reset and axiiv: reset wins and the sample is discarded.
- Reset mid-scan: returns immediately to reset state; the next sample starts a fresh window.
- axiid is ignored when axiiv=0.

Optional Feature:
- MINMAX_FILTER_STATS_EN defined: adds output ports.
  - range_out [SAMPLE_DATA_WIDTH:0]: last computed range; reset 0.
  - win_min [SAMPLE_DATA_WIDTH-1:0] and win_max [SAMPLE_DATA_WIDTH-1:0]: signed window extremes; reset 0.
  - range_valid: 1-cycle pulse in UPDATE.
- Undefined: those ports and their registers are absent. triggered behaviour is identical either way.

Decomposition:
- Package minmax_filter_pkg:
  - FSM state enum (IDLE, SCAN, UPDATE).
  - Range-width helper function.
  - Pointer-width localparam derivation ($clog2(LOOK_BACK)).
- Sub-module minmax_window_buf: simple dual-port circular sample RAM with a synchronous write port and a 1-cycle read port. The read latency is accounted for in SCAN sequencing.

Test Plan:
- Reset, then 600 samples of constant 5 → triggered stays 0; range 0.
- Reset, samples 0 then 80 → triggered=1 exactly 4 cycles after the second axiiv (count 2, +2).
- Full window holding values −40 and +40, then 500 samples of 0 → triggered stays 1 while the ±40 samples remain in the window. It drops to 0 at the update after the last ±40 sample is overwritten.
- Hysteresis/boundary:
  - Window range exactly 74 from idle → stays 0.
  - Range 75 → 1.
  - Then range 50 → stays 1.
  - Range 37 → stays 1.
  - Range 36 → 0.
- Extremes: samples −128 and 127 → range 255 and triggered=1, with no wrap to a small value.
- Mid-operation events:
  - A second axiiv 10 cycles into a 500-cycle scan → scan restarts, the new sample is included, exactly one update occurs.
  - rst=0 mid-scan → triggered=0 immediately; the count restarts from 0.
